// File: rtl/seg_counter_monitor.sv
// Two-digit seven-segment receiver: glitch filter, BCD decode and
// count-sequence checker with saturating error counter.
module seg_counter_monitor #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_COUNT     = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_1,
  input  logic [6:0] seg_10,
  output logic [3:0] digit_1,
  output logic [3:0] digit_10,
  output logic       value_valid,
  output logic       locked,
  output logic       seq_err,
  output logic       illegal_err,
  output logic [7:0] err_count
);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_t;

  localparam logic [3:0] SC    = 4'(STABLE_CYCLES);
  localparam logic [3:0] SC_M1 = 4'(STABLE_CYCLES - 1);
  localparam logic [6:0] MAXV  = 7'(MAX_COUNT);

  state_t      state;
  logic [13:0] samp;
  logic [13:0] last_pair;
  logic        have_last;
  logic [3:0]  stab_cnt;
  logic [6:0]  exp_val;

  logic [13:0] in_pair;
  logic [3:0]  cnt_nxt;
  logic        accept;
  logic [6:0]  lit_1;
  logic [6:0]  lit_10;
  logic [4:0]  dec_1;
  logic [4:0]  dec_10;
  logic        legal;
  logic [6:0]  val;
  logic [6:0]  val_nxt;

  // Segment pattern to {legal, bcd}; anything off-table is illegal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Stability filter and decode of the pair being sampled this edge.
  always_comb begin
    in_pair = {seg_10, seg_1};
    if (in_pair != samp)
      cnt_nxt = 4'd0;
    else if (stab_cnt >= SC)
      cnt_nxt = SC;
    else
      cnt_nxt = stab_cnt + 4'd1;
    accept  = (cnt_nxt == SC_M1) &&
              (!have_last || (in_pair != last_pair));
    lit_1   = ACTIVE_LOW ? ~seg_1  : seg_1;
    lit_10  = ACTIVE_LOW ? ~seg_10 : seg_10;
    dec_1   = decode(lit_1);
    dec_10  = decode(lit_10);
    legal   = dec_1[4] & dec_10[4];
    val     = ({3'd0, dec_10[3:0]} * 7'd10) + {3'd0, dec_1[3:0]};
    val_nxt = (val >= MAXV) ? 7'd0 : val + 7'd1;
  end

  assign locked = (state == LOCKED);

  // Sampling, acceptance and lock/sequence state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      samp        <= '0;
      last_pair   <= '0;
      have_last   <= 1'b0;
      stab_cnt    <= '0;
      exp_val     <= '0;
      digit_1     <= '0;
      digit_10    <= '0;
      value_valid <= 1'b0;
      seq_err     <= 1'b0;
      illegal_err <= 1'b0;
      err_count   <= '0;
    end else begin
      samp        <= in_pair;
      stab_cnt    <= cnt_nxt;
      seq_err     <= 1'b0;
      illegal_err <= 1'b0;
      if (accept) begin
        last_pair <= in_pair;
        have_last <= 1'b1;
        if (!legal) begin
          illegal_err <= 1'b1;
          value_valid <= 1'b0;
          state       <= UNLOCKED;
          if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
        end else begin
          digit_1     <= dec_1[3:0];
          digit_10    <= dec_10[3:0];
          value_valid <= 1'b1;
          exp_val     <= val_nxt;
          state       <= LOCKED;
          if ((state == LOCKED) && (val != exp_val)) begin
            seq_err <= 1'b1;
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/seg_counter_monitor.md
Name: seg_counter_monitor

Overview:
- Receiving end of the two-digit seven-segment interface driven by Two_Digit_Counter.
- Samples the seg_1 / seg_10 buses, filters short glitches, and decodes the patterns back to BCD digits.
- Checks that the displayed value advances by exactly one per change, wrapping MAX_COUNT -> 0.
- Flags illegal patterns and sequence breaks and keeps a saturating error count. Used as an on-chip self-check and as a bench checker.

Parameters:
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (inputs are inverted before decode); 0 = lit when bit is 1.
- STABLE_CYCLES, 2, consecutive identical samples (1..15) required before a new pattern pair is accepted.
- MAX_COUNT, 99, last value before wrap; expected successor of MAX_COUNT is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seg_1  in  7  ones-digit segments, bit order {g,f,e,d,c,b,a} = [6:0].
- seg_10  in  7  tens-digit segments, same bit order.
- digit_1  out  4  last accepted ones digit, BCD.
- digit_10  out  4  last accepted tens digit, BCD.
- value_valid  out  1  high once a legal value has been accepted since the last reset or illegal event.
- locked  out  1  high in the LOCKED state.
- seq_err  out  1  one-cycle pulse on a sequence break.
- illegal_err  out  1  one-cycle pulse on an accepted non-digit pattern.
- err_count  out  8  total error events; saturates at 255.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - digit_1 = 0, digit_10 = 0; value_valid, locked, seq_err, illegal_err = 0; err_count = 0.
  - Sample registers, stability counter and expected value cleared; state = UNLOCKED.
- Decode table, active-high form after optional inversion:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Any other pattern is illegal, including all-off.
- Sampling: {seg_10, seg_1} registered every clk edge into samp.
  - stab_cnt resets to 0 when samp changes.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
- Accept event: fires on the edge where stab_cnt reaches STABLE_CYCLES-1 and samp differs from the last accepted pair.
  - After reset the first stable pair always counts as new.
  - Latency: a new pair first sampled at edge E0 is accepted, and outputs update, at edge E0+STABLE_CYCLES-1.
  - Changes held for fewer than STABLE_CYCLES samples are ignored entirely.
- Illegal accept (either digit illegal):
  - illegal_err pulses; err_count +1.
  - State -> UNLOCKED; value_valid = 0; digit outputs hold their previous values.
  - Takes precedence over any sequence check in the same cycle.
- Legal accept, value V = 10*digit_10 + digit_1:
  - digit outputs = new digits; value_valid = 1.
  - UNLOCKED: load exp = next(V); state -> LOCKED.
  - LOCKED and V == exp: exp = next(V); no flag.
  - LOCKED and V != exp: seq_err pulses; err_count +1; exp = next(V) (resync); remains LOCKED.
  - next(V) = 0 if V >= MAX_COUNT, else V+1.
- Values above MAX_COUNT but with legal digits are accepted; the LOCKED check flags them as seq_err.
- The same pair held indefinitely produces no events.
- err_count saturates: at 255, further events still pulse their flags but the count stays at 255.
- A seq_err and an illegal_err never pulse in the same cycle.
- Reset asserted mid-filter or mid-lock discards all state immediately.

Test Plan:
- rst high 100 ns, then the counter stepping 00,01,02 (patterns held 10 cycles each, ACTIVE_LOW=1) -> locks on 00; digits track with latency STABLE_CYCLES-1 after sampling; seq_err never fires; err_count = 0.
- Wrap: drive 98,99,00,01 -> no seq_err across 99->00; locked stays 1.
- Skip: drive 05 then 07 -> one seq_err pulse on acceptance of 07; err_count = 1; then 08 is accepted without error.
- Glitch: stable 12, then 7F on seg_1 for 1 cycle, then back to 12 -> no accept, no flags, digits remain 1,2.
- Illegal: seg_1 = all-off held 5 cycles -> illegal_err pulse, value_valid = 0, locked = 0; a following legal 40 relocks with no seq_err.
- Saturation and reset: force 300 illegal/legal alternations -> err_count = 255; assert rst mid-run -> all outputs 0 asynchronously.
